// File: rtl/dot_pkg.sv
// Shared FP32 field definitions for the dot-product datapath: field widths,
// the default vector width and the unpacked-element record.
package dot_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = 24;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    localparam int unsigned DEFAULT_LANES = 4;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             zero;
        logic             inf;
        logic             nan;
    } fp_elem_t;

endpackage

// File: rtl/fp32_field_unpack.sv
// Combinational FP32 unpack: sign, biased exponent, significand with hidden bit
// and class flags. Subnormals are flushed to zero.
module fp32_field_unpack
    import dot_pkg::*;
(
    input  logic [31:0] word,
    output fp_elem_t    elem
);

    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;

    assign exp  = word[30:23];
    assign frac = word[22:0];

    always_comb begin
        elem      = '0;
        elem.sign = word[31];
        elem.exp  = exp;
        if (exp == '0) begin
            elem.zero = 1'b1;
        end else begin
            elem.sig = {1'b1, frac};
            if (exp == EXP_MAX) begin
                elem.inf = (frac == '0);
                elem.nan = (frac != '0);
            end
        end
    end

endmodule

// File: rtl/dot4_operand_unpacker.sv
// Operand front end: unpacks (A,B) FP32 pairs and gathers LANES of them into a
// registered frame, with a one-frame skid so the producer can stream at full rate.
module dot4_operand_unpacker
    import dot_pkg::*;
#(
    parameter int unsigned LANES = DEFAULT_LANES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_sign_a,
    output logic [LANES-1:0]         out_sign_b,
    output logic [EXP_W*LANES-1:0]   out_exp_a,
    output logic [EXP_W*LANES-1:0]   out_exp_b,
    output logic [SIG_W*LANES-1:0]   out_sig_a,
    output logic [SIG_W*LANES-1:0]   out_sig_b,
    output logic [LANES-1:0]         out_zero_a,
    output logic [LANES-1:0]         out_zero_b,
    output logic [LANES-1:0]         out_inf_a,
    output logic [LANES-1:0]         out_inf_b,
    output logic [LANES-1:0]         out_nan_a,
    output logic [LANES-1:0]         out_nan_b
);

    localparam int unsigned CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    fp_elem_t elem_a, elem_b;

    fp32_field_unpack u_unpack_a (
        .word (in_a),
        .elem (elem_a)
    );

    fp32_field_unpack u_unpack_b (
        .word (in_b),
        .elem (elem_b)
    );

    logic [CW-1:0]          cnt_q;
    fp_elem_t [LANES-2:0]   fill_a_q, fill_b_q;
    fp_elem_t [LANES-1:0]   frame_a_q, frame_b_q;
    logic                   out_valid_q;
    logic                   last, accept, complete;

    assign last     = (cnt_q == LAST);
    // Only the completing pair needs room in the output register.
    assign in_ready = !last || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            fill_a_q    <= '0;
            fill_b_q    <= '0;
            frame_a_q   <= '0;
            frame_b_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= cnt_q + CW'(1);
                if (!last) begin
                    fill_a_q[cnt_q] <= elem_a;
                    fill_b_q[cnt_q] <= elem_b;
                end
            end
            // A loading frame wins over a consume on the same edge.
            if (complete) begin
                frame_a_q   <= {elem_a, fill_a_q};
                frame_b_q   <= {elem_b, fill_b_q};
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;

    always_comb begin
        out_sign_a = '0;
        out_sign_b = '0;
        out_exp_a  = '0;
        out_exp_b  = '0;
        out_sig_a  = '0;
        out_sig_b  = '0;
        out_zero_a = '0;
        out_zero_b = '0;
        out_inf_a  = '0;
        out_inf_b  = '0;
        out_nan_a  = '0;
        out_nan_b  = '0;
        for (int k = 0; k < LANES; k++) begin
            out_sign_a[k]            = frame_a_q[k].sign;
            out_sign_b[k]            = frame_b_q[k].sign;
            out_exp_a[EXP_W*k +: EXP_W] = frame_a_q[k].exp;
            out_exp_b[EXP_W*k +: EXP_W] = frame_b_q[k].exp;
            out_sig_a[SIG_W*k +: SIG_W] = frame_a_q[k].sig;
            out_sig_b[SIG_W*k +: SIG_W] = frame_b_q[k].sig;
            out_zero_a[k]            = frame_a_q[k].zero;
            out_zero_b[k]            = frame_b_q[k].zero;
            out_inf_a[k]             = frame_a_q[k].inf;
            out_inf_b[k]             = frame_b_q[k].inf;
            out_nan_a[k]             = frame_a_q[k].nan;
            out_nan_b[k]             = frame_b_q[k].nan;
        end
    end

endmodule

// File: doc/dot4_operand_unpacker.md
# dot4_operand_unpacker

Front-end operand stage of the reconfigurable dot-product unit: the input-side counterpart of the final FP32 adder/rounder. It accepts packed IEEE-754 single-precision element pairs (A_k, B_k) one pair per cycle over a valid/ready stream. It unpacks each element into sign, biased exponent, 24-bit significand with hidden bit, and class flags. It then assembles LANES pairs into one registered frame for the multiplier array, with a one-frame skid so the producer streams at full rate.

## Interface
- LANES, 4, elements per vector frame; power of two, at least 2
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a pair on in_a/in_b
- in_ready  out  1  block accepts the pair this cycle
- in_a, in_b  in  32  packed FP32 elements
- out_valid  out  1  frame registered and stable
- out_ready  in  1  consumer takes the frame this cycle
- out_sign_a, out_sign_b  out  LANES  sign bit, lane k at bit k
- out_exp_a, out_exp_b  out  8*LANES  biased exponent, lane k at [8k+:8]
- out_sig_a, out_sig_b  out  24*LANES  {hidden, fraction}, lane k at [24k+:24]
- out_zero_a/b, out_inf_a/b, out_nan_a/b  out  LANES each  per-lane class flags

## Operation
- Per-element unpack, identical for A and B:
  - exp==0: zero=1; sig=0 (subnormals flushed to zero); sign passes through
  - exp==255, frac==0: inf=1, sig={1,frac}
  - exp==255, frac!=0: nan=1, sig={1,frac}
  - otherwise: sig={1'b1,frac}
  - exp is always passed unchanged
- Fill buffer: lane counter cnt (log2 LANES bits, reset 0). The pair accepted with cnt=k is written to fill lane k, and cnt increments, wrapping to 0 after LANES-1.
- The accept with cnt=LANES-1 completes the frame. Lanes 0..LANES-2 come from the fill buffer and lane LANES-1 from the current input. The complete frame loads the output register in the same edge, and out_valid is set.
- in_ready = (cnt != LANES-1) || !out_valid || out_ready. Only the completing pair can stall. Partial lanes are never overwritten while stalled.
- out_valid clears on out_valid && out_ready unless a new frame loads in the same edge. In that case it stays 1 and the data is replaced.
- No partial-frame flush. A frame is emitted only after exactly LANES accepts.

## Timing
- Reset (async assert, sync-safe deassert): cnt=0, out_valid=0, in_ready=1, and every out_* data/flag register is 0. A partially collected frame is discarded.
- Latency: out_valid rises the cycle after the edge that accepts the LANES-th pair.
- Throughput: one pair per cycle sustained, one frame per LANES cycles when out_ready is held 1.
- While out_valid && !out_ready, all out_* are held stable.
- Simultaneous completing accept and output consume: legal, and there is no bubble.
- in_valid with in_ready=0: no state change. The producer must hold its data.

## Structure
- Shared package `dot_pkg`:
  - FP32 field constants: EXP_W=8, FRAC_W=23, SIG_W=24, EXP_MAX=8'hFF
  - LANES default
  - unpacked-element struct {sign, exp, sig, zero, inf, nan}
  - These are the same widths the final adder consumes.
- Sub-module `fp32_field_unpack`: purely combinational, 32-bit in to the struct out. It is instantiated twice (A, B) ahead of the fill buffer.
- Top: counter, fill buffer of LANES-1 lanes, output register, ready logic.

## Test plan
- Basic frame: pairs (0x3F800000,0x40000000), (0xBF800000,0x3F000000), (0x00000000,0x7F800000), (0x7FC00001,0x00000001) with out_ready=1. Required after the 4th accept + 1 cycle:
  - lane0 A: sign0, exp 0x7F, sig 0x800000
  - lane1 A: sign1
  - lane2 A: zero=1; lane2 B: inf=1, sig 0x800000
  - lane3 A: nan=1, sig 0xC00001; lane3 B: subnormal flushed, zero=1, sig 0
- Streaming: 12 back-to-back pairs with out_ready=1 -> in_ready never drops; out_valid pulses on cycles 5, 9, 13 (1-cycle wide); frames match inputs in order.
- Backpressure: out_ready=0 after first frame, keep in_valid=1 -> 3 further pairs accepted, in_ready=0 with cnt=3, first frame held stable. Raising out_ready for 1 cycle -> old frame consumed and new frame loaded on the same edge, out_valid stays 1.
- Sparse input: in_valid toggled 1/0 -> frame emitted only after 4 accepts, lane order preserved.
- Reset mid-frame: assert rst after 2 accepts -> all outputs 0, in_ready=1. The next 4 pairs form a clean frame with no stale lanes.
- Exponent boundaries: 0x00800000 -> exp 0x01, sig 0x800000, no flags. 0x7F7FFFFF -> exp 0xFE, sig 0xFFFFFF, no flags.
